// File: rtl/packet_input_arbiter.sv
// Round-robin arbiter that merges NUM_SRC valid/ready packet producers into a
// one-entry holding register, read by the core through an empty/read_req port.
module packet_input_arbiter #(
  parameter int PACKET_WIDTH = 32,
  parameter int NUM_SRC      = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC*PACKET_WIDTH-1:0] src_packet,
  input  logic [NUM_SRC-1:0]              src_valid,
  output logic [NUM_SRC-1:0]              src_ready,
  input  logic                            tick,
  input  logic                            read_req,
  output logic [PACKET_WIDTH-1:0]         packet_in,
  output logic                            input_buffer_empty,
  output logic [$clog2(NUM_SRC)-1:0]      grant_src,
  output logic                            read_error,
  output logic [CNT_WIDTH-1:0]            fwd_count
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

  logic                    hold_valid;
  logic [PACKET_WIDTH-1:0] hold_data;
  logic [IDX_W-1:0]        hold_src;
  logic [IDX_W-1:0]        rr_ptr;

  logic                    pop;
  logic                    can_load;
  logic                    transfer;
  logic                    grant_found;
  logic [IDX_W-1:0]        grant_idx;
  logic [IDX_W-1:0]        cand_idx;
  int                      cand;

  logic [PACKET_WIDTH-1:0] src_pkt [NUM_SRC];

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_unpack
    assign src_pkt[s] = src_packet[s*PACKET_WIDTH +: PACKET_WIDTH];
  end

  assign pop      = read_req & hold_valid;
  // rst gating keeps src_ready low during reset so no handshake completes on a reset edge
  assign can_load = !rst & !tick & (!hold_valid | pop);
  assign transfer = grant_found & can_load;

  // Search starts one past the last granted source and wraps modulo NUM_SRC.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand     = (int'(rr_ptr) + i) % NUM_SRC;
      cand_idx = IDX_W'(cand);
      if (!grant_found && src_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    src_ready = '0;
    if (transfer) src_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_src   <= '0;
      rr_ptr     <= LAST_IDX;
      read_error <= 1'b0;
      fwd_count  <= '0;
    end else begin
      if (transfer) begin
        hold_valid <= 1'b1;
        hold_data  <= src_pkt[grant_idx];
        hold_src   <= grant_idx;
        rr_ptr     <= grant_idx;
      end else if (pop) begin
        hold_valid <= 1'b0;
        hold_data  <= '0;
      end
      if (pop) fwd_count <= fwd_count + 1'b1;
      if (read_req && !hold_valid) read_error <= 1'b1;
    end
  end

  assign packet_in          = hold_valid ? hold_data : '0;
  assign input_buffer_empty = !hold_valid;
  assign grant_src          = hold_valid ? hold_src : '0;

endmodule

// File: tb/tb_packet_input_arbiter.sv
// Directed bench for packet_input_arbiter: reset, rotation, skip, backpressure,
// tick freeze, sticky read error and counter wrap (CNT_WIDTH=4).
module tb_packet_input_arbiter;

  localparam int PW = 32;
  localparam int NS = 4;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NS*PW-1:0] src_packet;
  logic [NS-1:0]  src_valid;
  logic [NS-1:0]  src_ready;
  logic           tick;
  logic           read_req;
  logic [PW-1:0]  packet_in;
  logic           input_buffer_empty;
  logic [1:0]     grant_src;
  logic           read_error;
  logic [CW-1:0]  fwd_count;

  int checks = 0;
  int errors = 0;

  packet_input_arbiter #(.PACKET_WIDTH(PW), .NUM_SRC(NS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .src_packet(src_packet), .src_valid(src_valid),
    .src_ready(src_ready), .tick(tick), .read_req(read_req), .packet_in(packet_in),
    .input_buffer_empty(input_buffer_empty), .grant_src(grant_src),
    .read_error(read_error), .fwd_count(fwd_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; read_req = 1'b1; src_valid = 4'hF;
    for (int i = 0; i < NS; i++) src_packet[i*PW +: PW] = 32'hA000_0000 + i;

    // reset with everything requesting
    step();
    chk("rst_ready", 32'(src_ready), 32'h0);
    chk("rst_empty", 32'(input_buffer_empty), 32'h1);
    chk("rst_pkt", packet_in, 32'h0);
    chk("rst_cnt", 32'(fwd_count), 32'h0);
    chk("rst_err", 32'(read_error), 32'h0);
    chk("rst_grant", 32'(grant_src), 32'h0);

    // first grant is source 0
    rst = 1'b0; read_req = 1'b0;
    #1 chk("first_ready", 32'(src_ready), 32'h1);
    step();
    chk("first_pkt", packet_in, 32'hA000_0000);
    chk("first_grant", 32'(grant_src), 32'h0);
    chk("first_empty", 32'(input_buffer_empty), 32'h0);
    chk("held_ready", 32'(src_ready), 32'h0);

    // round robin at one packet per cycle
    read_req = 1'b1;
    #1 chk("rr_ready", 32'(src_ready), 32'h2);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("rr_pkt", packet_in, 32'hA000_0000 + 32'(k % 4));
    end
    chk("rr_cnt8", 32'(fwd_count), 32'h8);

    // drain, then backpressure with only source 0
    src_valid = 4'h0;
    step();
    chk("drain_empty", 32'(input_buffer_empty), 32'h1);
    chk("drain_pkt", packet_in, 32'h0);
    chk("drain_cnt", 32'(fwd_count), 32'h9);
    read_req = 1'b0; src_valid = 4'h1;
    #1 chk("bp_ready0", 32'(src_ready), 32'h1);
    step();
    chk("bp_pkt", packet_in, 32'hA000_0000);
    chk("bp_ready1", 32'(src_ready), 32'h0);
    step();
    chk("bp_hold_pkt", packet_in, 32'hA000_0000);
    chk("bp_hold_empty", 32'(input_buffer_empty), 32'h0);
    src_packet[0 +: PW] = 32'h1234_5678; read_req = 1'b1;
    #1 chk("bp_pop_ready", 32'(src_ready), 32'h1);
    step();
    chk("bp_refill_pkt", packet_in, 32'h1234_5678);
    chk("bp_refill_empty", 32'(input_buffer_empty), 32'h0);
    chk("bp_cnt", 32'(fwd_count), 32'hA);

    // skip: only sources 1 and 3
    src_valid = 4'hA;
    step();
    chk("skip_g1", 32'(grant_src), 32'h1);
    step(); chk("skip_g3a", 32'(grant_src), 32'h3);
    step(); chk("skip_g1a", 32'(grant_src), 32'h1);
    step(); chk("skip_g3b", 32'(grant_src), 32'h3);
    step(); chk("skip_g1b", 32'(grant_src), 32'h1);
    src_valid = 4'hE;
    step(); chk("fair_g2", 32'(grant_src), 32'h2);
    chk("fair_pkt2", packet_in, 32'hA000_0002);
    step(); chk("fair_g3", 32'(grant_src), 32'h3);
    step(); chk("fair_g1", 32'(grant_src), 32'h1);
    chk("fair_cnt", 32'(fwd_count), 32'h2);

    // tick freeze for three cycles
    src_valid = 4'hF; tick = 1'b1;
    #1 chk("tick_ready0", 32'(src_ready), 32'h0);
    step();
    chk("tick_empty1", 32'(input_buffer_empty), 32'h1);
    chk("tick_ready1", 32'(src_ready), 32'h0);
    read_req = 1'b0;
    step();
    chk("tick_empty2", 32'(input_buffer_empty), 32'h1);
    chk("tick_ready2", 32'(src_ready), 32'h0);
    step();
    chk("tick_empty3", 32'(input_buffer_empty), 32'h1);
    tick = 1'b0;
    #1 chk("tick_resume_ready", 32'(src_ready), 32'h4);
    step();
    chk("tick_resume_grant", 32'(grant_src), 32'h2);
    chk("tick_resume_pkt", packet_in, 32'hA000_0002);
    chk("tick_cnt", 32'(fwd_count), 32'h3);

    // read while empty, combined with a load on the same edge
    src_valid = 4'h0; read_req = 1'b1;
    step();
    chk("err_pre", 32'(read_error), 32'h0);
    src_valid = 4'h1;
    step();
    chk("err_set", 32'(read_error), 32'h1);
    chk("err_load_grant", 32'(grant_src), 32'h0);
    chk("err_load_empty", 32'(input_buffer_empty), 32'h0);
    chk("err_cnt", 32'(fwd_count), 32'h4);
    src_valid = 4'h0; read_req = 1'b0;
    step(); step();
    chk("err_sticky", 32'(read_error), 32'h1);

    // reset clears error; 17 pops wrap a 4-bit counter to 1
    rst = 1'b1; src_valid = 4'hF; read_req = 1'b1;
    step();
    chk("rst2_err", 32'(read_error), 32'h0);
    chk("rst2_empty", 32'(input_buffer_empty), 32'h1);
    rst = 1'b0; read_req = 1'b0;
    step();
    chk("rst2_grant", 32'(grant_src), 32'h0);
    read_req = 1'b1;
    for (int k = 0; k < 17; k++) step();
    chk("wrap_cnt", 32'(fwd_count), 32'h1);
    chk("wrap_err", 32'(read_error), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_input_arbiter.md
# packet_input_arbiter

Round-robin arbiter that shares the core's single input-buffer port between NUM_SRC packet producers (router ports, host injection, test stimulus). It collects packets through per-source valid/ready handshakes into a one-entry holding register. It presents that register to the core through the packet_in / input_buffer_empty / read_req interface the core already uses. A tick input freezes new acceptance so the core can finish a timestep cleanly. Error and count outputs support bring-up.

## Interface
- PACKET_WIDTH, 32, width of one spike packet
- NUM_SRC, 4, number of requesting sources (>=2, power of two not required)
- CNT_WIDTH, 16, width of forwarded-packet counter

- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- src_packet  in  NUM_SRC*PACKET_WIDTH  source i packet at bits [i*PACKET_WIDTH +: PACKET_WIDTH]
- src_valid  in  NUM_SRC  source i has a packet
- src_ready  out  NUM_SRC  one-hot or zero; source i packet accepted on the edge where src_valid[i] & src_ready[i]
- tick  in  1  timestep boundary; while high, no new packet accepted
- read_req  in  1  core pops the presented packet
- packet_in  out  PACKET_WIDTH  presented packet; 0 when empty
- input_buffer_empty  out  1  high when no packet is presented
- grant_src  out  $clog2(NUM_SRC)  source index of presented packet; 0 when empty
- read_error  out  1  sticky; read_req seen while empty
- fwd_count  out  CNT_WIDTH  packets popped by the core, wraps

## Operation
- State: hold_valid, hold_data, hold_src, rr_ptr (last granted index), read_error, fwd_count.
- pop = read_req & hold_valid.
- can_load = !tick & (!hold_valid | pop).
- Arbitration, combinational: search src_valid in order rr_ptr+1, rr_ptr+2, … modulo NUM_SRC. The first set index g wins. src_ready[g] = can_load, and all other bits are 0. src_ready is 0 when no source is valid or can_load=0.
- On a transfer into g: hold_data <= packet of g, hold_src <= g, hold_valid <= 1, rr_ptr <= g. rr_ptr changes only on a transfer.
- On a pop with no transfer: hold_valid <= 0 and hold_data <= 0.
- fwd_count increments by 1 on every pop and wraps from 2^CNT_WIDTH-1 to 0.
- read_req while hold_valid=0 sets read_error. The read has no other effect: no pop and no count. read_error clears only on rst.
- Outputs: packet_in = hold_valid ? hold_data : 0; input_buffer_empty = !hold_valid; grant_src = hold_valid ? hold_src : 0.
- Fairness: with all sources continuously valid, grants rotate 0,1,…,NUM_SRC-1,0,…. No source waits more than NUM_SRC-1 transfers once valid.

## Timing
- Reset (rst high at an edge): hold_valid=0, hold_data=0, hold_src=0, rr_ptr=NUM_SRC-1 (source 0 has first priority), read_error=0, fwd_count=0.
- During reset, src_ready=0 irrespective of inputs.
- Reset mid-transfer: a packet in the holding register is discarded, and no handshake completes on the reset edge.
- Load latency: a transfer at edge N means packet_in/grant_src are valid and input_buffer_empty=0 after edge N (1 cycle).
- Pop: read_req high with empty=0 at edge M consumes the presented packet.
- Simultaneous pop and load at edge M: the new packet is presented after M with no bubble. Sustained throughput is 1 packet/cycle.
- tick high: src_ready=0 that cycle, while pops continue. With tick held and read_req high, the arbiter drains to empty within 1 cycle. tick has no effect on rr_ptr.
- Sources must hold src_packet/src_valid stable until accepted. src_ready never depends on src_packet.
- read_error rises the cycle after the offending edge. Simultaneous read_req while empty plus a load at the same edge sets read_error, and the load still occurs.

## Test plan
- Reset check: assert rst with all src_valid=1 and read_req=1 -> src_ready=0, input_buffer_empty=1, packet_in=0, fwd_count=0, read_error=0. After release, first grant is source 0.
- Round-robin: 4 sources always valid, packets 0xA0000000+i, read_req held high -> packet_in sequence A0,A1,A2,A3,A0… one per cycle; fwd_count=8 after 8 pops.
- Skip/fairness: only sources 1 and 3 valid, rr_ptr=1 -> grants 3,1,3,1. Then source 2 asserts -> it is granted before 3 on the next turn after 1.
- Backpressure: read_req=0, source 0 valid -> one load, then src_ready=0 and packet held stable with empty=0. read_req=1 for one cycle -> pop and refill on the same edge.
- Tick: tick=1 for 3 cycles with sources valid and a packet held, read_req=1 -> one pop, then empty=1 and no src_ready for 3 cycles. Acceptance resumes on the cycle tick falls.
- Errors and wrap: read_req while empty -> read_error=1, sticky until rst. CNT_WIDTH=4 with 17 pops -> fwd_count=1.
